// File: rtl/sync_uart_rx.sv
// Purpose: 8N1 UART receiver with 2-flop input synchronizer and a one-entry valid/ready output register.
// Latency: byte presented on the cycle after the stop-bit sample (2 sync cycles + HALF + 9*BIT_TICKS + 1 after rx falls).
// Backpressure: a byte arriving while the register is full and not being consumed is dropped with an overrun pulse.
module sync_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD;
  localparam int HALF      = BIT_TICKS / 2;
  localparam logic [15:0] BIT_RELOAD  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [15:0] r_bit_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ferr;
  logic        r_ovr;

  state_t      w_state_nxt;
  logic [15:0] w_bit_timer_nxt;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic        w_ferr_nxt;
  logic        w_ovr_nxt;
  logic        w_rx_s;
  logic        w_timer_zero;

  assign w_rx_s       = r_sync2;
  assign w_timer_zero = (r_bit_timer == 16'd0);

  // Two-flop synchronizer for the asynchronous line; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // State, counters, shift register and output register all update from the next-value logic below.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_timer <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_timer <= w_bit_timer_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_ferr      <= w_ferr_nxt;
      r_ovr       <= w_ovr_nxt;
    end
  end

  // Next-state, bit timing, and byte delivery into the one-entry output register.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_timer_nxt = r_bit_timer;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    // A completed handshake empties the register unless a delivery below refills it.
    w_valid_nxt     = r_valid & ~rx_ready;
    w_ferr_nxt      = 1'b0;
    w_ovr_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_bit_timer_nxt = HALF_RELOAD;
          w_state_nxt     = START;
        end
      end

      START: begin
        if (w_timer_zero) begin
          if (!w_rx_s) begin
            w_bit_timer_nxt = BIT_RELOAD;
            w_bit_idx_nxt   = 3'd0;
            w_state_nxt     = DATA;
          end else begin
            // Line went back high before mid-start-bit: a glitch, not a frame.
            w_state_nxt = IDLE;
          end
        end else begin
          w_bit_timer_nxt = r_bit_timer - 16'd1;
        end
      end

      DATA: begin
        if (w_timer_zero) begin
          w_shift_nxt     = {w_rx_s, r_shift[7:1]};
          w_bit_timer_nxt = BIT_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_bit_timer_nxt = r_bit_timer - 16'd1;
        end
      end

      STOP: begin
        if (w_timer_zero) begin
          if (w_rx_s) begin
            if (!r_valid || rx_ready) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_bit_timer_nxt = r_bit_timer - 16'd1;
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line is released so a break does not start a new frame.
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign data_out  = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_sync_uart_rx.sv
// Purpose: scoreboard bench for sync_uart_rx at BIT_TICKS=16, HALF=8.
// Latency: expected events carry the exact cycle they must appear in.
// Backpressure: rx_ready is driven per scenario to exercise hold, accept and overrun.
`timescale 1ns/1ps
module tb_sync_uart_rx;

  localparam int BT  = 16;
  // Cycles from the first drive of a start bit to the output cycle:
  // 2 synchronizer cycles + HALF (8) + 9*BT (144) + 1 registered output.
  localparam int LAT = 155;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  sync_uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef enum int {EV_BYTE = 0, EV_FERR = 1, EV_OVR = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%02h at cycle %0d, expected no event", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d data 0x%02h cycle %0d, expected kind %0d data 0x%02h cycle %0d",
                 k, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: samples on the falling edge, turns DUT outputs into events and checks them against the queue.
  logic       prev_valid = 1'b0;
  logic       prev_acc   = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rx_valid && prev_valid && !prev_acc) check("data_hold", {24'd0, data_out}, {24'd0, prev_data});
    if (rx_valid && (!prev_valid || prev_acc)) got(EV_BYTE, data_out);
    if (frame_err) got(EV_FERR, 8'h00);
    if (overrun) got(EV_OVR, 8'h00);
    prev_valid = rx_valid;
    prev_acc   = rx_valid && rx_ready;
    prev_data  = data_out;
  end

  // Drives one frame, LSB first; must be entered 1 ns after a rising edge and returns the same way.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] line;
    line = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = line[i];
      repeat (BT) @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       bad;
    logic [7:0] pre;

    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Idle line stays quiet
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (busy || rx_valid || frame_err || overrun || data_out != 8'h00) bad = 1'b1;
    end
    check("idle_quiet", {31'd0, bad}, 32'd0);

    // Single byte 0xA5, held until accepted
    push(EV_BYTE, 8'hA5, cyc + LAT);
    send_frame(8'hA5, 1'b1);
    step(20);
    check("a5_held_valid", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    check("a5_cleared", {31'd0, rx_valid}, 32'd0);

    // Back-to-back with the register full: second byte dropped
    push(EV_BYTE, 8'h3C, cyc + LAT);
    send_frame(8'h3C, 1'b1);
    push(EV_OVR, 8'h00, cyc + LAT);
    send_frame(8'hC3, 1'b1);
    step(4);
    check("ovr_keeps_old", {24'd0, data_out}, 32'h3C);
    rx_ready = 1'b1;
    step(1);
    check("ovr_drained", {31'd0, rx_valid}, 32'd0);

    // Back-to-back with consumer always ready
    push(EV_BYTE, 8'h3C, cyc + LAT);
    send_frame(8'h3C, 1'b1);
    push(EV_BYTE, 8'hC3, cyc + LAT);
    send_frame(8'hC3, 1'b1);
    step(4);
    rx_ready = 1'b0;
    step(4);

    // Framing error followed by a held-low line
    push(EV_FERR, 8'h00, cyc + LAT);
    send_frame(8'h55, 1'b0);
    step(40);
    check("ferr_busy_while_low", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    step(2);
    check("ferr_busy_sync_delay", {31'd0, busy}, 32'd1);
    step(1);
    check("ferr_busy_released", {31'd0, busy}, 32'd0);
    check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    step(10);

    // Start-bit glitch, then a real frame
    rx = 1'b0;
    step(4);
    check("glitch_seen_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    step(16);
    check("glitch_back_idle", {31'd0, busy}, 32'd0);
    push(EV_BYTE, 8'h81, cyc + LAT);
    send_frame(8'h81, 1'b1);
    step(8);

    // Reset during data bit 4 of 0xFF; 0x81 is still pending in the register
    check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    pre = 8'hFF;
    rx  = 1'b0;
    step(BT);
    for (int i = 0; i < 4; i++) begin
      rx = pre[i];
      step(BT);
    end
    rx = pre[4];
    step(8);
    rst = 1'b1;
    step(1);
    check("midrst_data_out", {24'd0, data_out}, 32'h00);
    check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    rx  = 1'b1;
    step(40);
    push(EV_BYTE, 8'h0F, cyc + LAT);
    send_frame(8'h0F, 1'b1);
    step(50);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_uart_rx.md
# sync_uart_rx

Synchronous UART receiver: the stage directly downstream of the team's UART transmitter on a serial link. It recovers 8N1 frames from an asynchronous serial line and presents each received byte on a one-entry valid/ready output register. Framing errors and overruns are reported as single-cycle pulses. The block sits between the board RX pin and any byte consumer, such as a FIFO or command parser.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s; BIT_TICKS = CLK_FREQ/BAUD (integer division), legal range 4..65535; HALF = BIT_TICKS/2 (integer division)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- rx_ready  in  1  consumer accepts data_out when high together with rx_valid
- data_out  out  8  last received byte, held while rx_valid is high
- rx_valid  out  1  data_out holds an unconsumed byte
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: new byte dropped because the register was full
- busy  out  1  high in every state except IDLE

## Operation
- Input synchronizer: rx passes through two flops, both reset to 1. All decisions use the second flop's output, rx_s.
- Receive counters:
  - bit_timer: 16 bits.
  - bit_idx: 3 bits.
  - shift: 8 bits; right-shift with rx_s entering bit 7, so the byte arrives LSB first.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - When rx_s == 0: bit_timer <= HALF-1, go to START.
- START: decrement bit_timer. When bit_timer == 0:
  - rx_s == 0: bit_timer <= BIT_TICKS-1, bit_idx <= 0, go to DATA.
  - rx_s == 1: treat as a glitch; go to IDLE with no output activity.
- DATA: decrement bit_timer. When bit_timer == 0:
  - Shift in rx_s and reload bit_timer <= BIT_TICKS-1.
  - If bit_idx == 7, go to STOP; otherwise bit_idx++.
- STOP: decrement bit_timer. When bit_timer == 0:
  - rx_s == 1: deliver the byte (see output register rules below), then go to IDLE.
  - rx_s == 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s == 1, then go to IDLE. This prevents a break condition from retriggering reception.
- Output register, applied on byte delivery:
  - rx_valid == 0, or rx_ready == 1 in the same cycle: data_out <= shift, rx_valid <= 1.
  - rx_valid == 1 and rx_ready == 0: keep the old data_out, pulse overrun, drop the new byte.
- Handshake: rx_valid clears on the cycle after rx_valid && rx_ready, unless a new byte is delivered in that same cycle, in which case it stays 1.
- Reset:
  - All outputs are 0; the FSM is in IDLE; counters and shift are 0.
  - Synchronizer flops reset to 1.
  - rst asserted mid-frame aborts the frame; nothing is delivered.

## Timing
- Let n be the first cycle rx_s == 0 while in IDLE. Rx_s lags rx by 2 cycles.
- Sample points:
  - Start bit is sampled at cycle n+HALF.
  - Data bit k (k = 0..7) is sampled at n+HALF+(k+1)*BIT_TICKS.
  - Stop bit is sampled at n+HALF+9*BIT_TICKS.
- Outputs from a good frame: rx_valid rises, and data_out updates, in cycle n+HALF+9*BIT_TICKS+1.
- Outputs from an errored or dropped frame: frame_err or overrun is high in that same cycle, and for exactly 1 cycle.
- After a good stop bit the FSM is back in IDLE one cycle after the stop sample. Back-to-back frames with no idle gap are therefore received.
- busy rises the cycle after n and falls the cycle after the stop sample, or on leaving WAIT_IDLE.
- frame_err and overrun never both assert for one frame.

## Test plan
- Use CLK_FREQ=16, BAUD=1 (BIT_TICKS=16, HALF=8) unless stated.
- Reset then idle line:
  - After rst, data_out=0x00, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - They stay so for 200 cycles with rx=1.
- Single byte:
  - Drive frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit), rx_ready=0.
  - rx_valid=1 with data_out=0xA5 at cycle n+153.
  - It holds until rx_ready=1, then clears the next cycle.
- Back-to-back with overrun:
  - Send 0x3C then 0xC3 with no gap, rx_ready=0.
  - data_out stays 0x3C; overrun pulses 1 cycle at the second frame's stop sample.
  - Repeat with rx_ready=1 held: both bytes are seen as valid in order, with no overrun.
- Framing error:
  - Send 0x55 with stop bit 0, and hold rx=0 for 40 more cycles.
  - frame_err pulses once, rx_valid stays 0, busy stays 1 until 1 cycle after rx returns to 1.
- Start glitch:
  - Drive rx=0 for 4 cycles, then 1.
  - FSM returns to IDLE; no rx_valid and no frame_err.
  - A following 0x81 frame is received correctly.
- Reset mid-frame:
  - Assert rst during data bit 4 of 0xFF.
  - All outputs are 0 next cycle; no byte is delivered.
  - A subsequent 0x0F frame is received correctly.
